// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, special encodings
// and the square-root sequencer state type.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ITER,
        ROUND,
        DONE
    } sqrt_state_t;

endpackage

// File: rtl/fpu_sqrt_step.sv
// One restoring square-root step: bring down two radicand bits and try to
// subtract (4*root + 1); keep the difference only when it does not go negative.
module fpu_sqrt_step (
    input  logic [27:0] rem,
    input  logic [25:0] root,
    input  logic [1:0]  bits,
    output logic [27:0] rem_next,
    output logic        root_bit
);

    logic [29:0] acc;
    logic [30:0] diff;

    // The widened trial keeps the borrow in diff[30]; a kept remainder never
    // exceeds 2*root, so 28 bits hold it in both outcomes.
    always_comb begin
        acc      = {rem, bits};
        diff     = {1'b0, acc} - {3'b000, root, 2'b01};
        root_bit = ~diff[30];
        rem_next = root_bit ? 28'(diff) : 28'(acc);
    end

endmodule

// File: rtl/fpu_sqrt_unit.sv
// Iterative single-precision square root: special-case bypass, 26 restoring
// steps over a 52-bit radicand, then round-to-nearest-even.
module fpu_sqrt_unit
    import fpu_pkg::*;
#(
    parameter int ITERS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand,
    output logic [31:0] result,
    output logic        ready,
    output logic        done,
    output logic        invalid,
    output logic        inexact
);

    sqrt_state_t state;

    logic [31:0] op;
    logic [51:0] rad;
    logic [27:0] rem;
    logic [25:0] root;
    logic [4:0]  cnt;
    logic [7:0]  exp_q;

    logic [27:0] rem_next;
    logic        root_bit;

    logic              sign;
    logic [EXP_W-1:0]  exp_in;
    logic [FRAC_W-1:0] frac_in;
    logic              is_zero;
    logic              is_nan;
    logic              special;
    logic [31:0]       special_res;
    logic              special_inv;
    logic signed [9:0] e_unb;
    logic signed [9:0] e_even;
    logic [24:0]       m_adj;
    logic [7:0]        exp_next;

    function automatic logic [32:0] round_pack(input logic [7:0]  exp_val,
                                               input logic [24:0] rt,
                                               input logic        sticky);
        logic        inc;
        logic [23:0] mant;
        logic [7:0]  exp_out;
        inc     = rt[1] & (rt[0] | sticky | rt[2]);
        mant    = {1'b0, rt[24:2]} + {23'd0, inc};
        exp_out = exp_val + {7'd0, mant[23]};
        return {rt[1] | rt[0] | sticky, 1'b0, exp_out, mant[22:0]};
    endfunction

    always_comb begin
        sign        = op[31];
        exp_in      = op[30:23];
        frac_in     = op[22:0];
        is_zero     = (exp_in == '0);
        is_nan      = (exp_in == '1) && (frac_in != '0);
        special     = is_zero | (exp_in == '1) | sign;
        special_inv = 1'b0;
        if (is_zero) begin
            special_res = {sign, 31'd0};
        end else if (is_nan) begin
            special_res = FP_QNAN;
        end else if (sign) begin
            special_res = FP_QNAN;
            special_inv = 1'b1;
        end else begin
            special_res = FP_PINF;
        end

        // Odd exponents borrow one factor of two into the mantissa so the
        // halved exponent stays exact.
        e_unb = $signed({2'b00, exp_in}) - $signed(10'(EXP_BIAS));
        if (e_unb[0]) begin
            m_adj  = {1'b1, frac_in, 1'b0};
            e_even = e_unb - 10'sd1;
        end else begin
            m_adj  = {1'b0, 1'b1, frac_in};
            e_even = e_unb;
        end
        exp_next = 8'((e_even >>> 1) + $signed(10'(EXP_BIAS)));
    end

    fpu_sqrt_step u_step (
        .rem      (rem),
        .root     (root),
        .bits     (rad[51:50]),
        .rem_next (rem_next),
        .root_bit (root_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            result  <= '0;
            invalid <= 1'b0;
            inexact <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= operand;
                        ready <= 1'b0;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        result  <= special_res;
                        invalid <= special_inv;
                        inexact <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        rad   <= {m_adj, 27'd0};
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= '0;
                        exp_q <= exp_next;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem  <= rem_next;
                    root <= {root[24:0], root_bit};
                    rad  <= rad << 2;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'(ITERS - 1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    {inexact, result} <= round_pack(exp_q, root[24:0], rem != '0);
                    invalid <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sqrt_unit.sv
// Bench for fpu_sqrt_unit: directed and random operands scored against an
// integer-sqrt reference model with cycle-exact handshake expectations.
module tb_fpu_sqrt_unit;

    localparam int LAT_SPECIAL = 2;
    localparam int LAT_NORMAL  = 29;

    typedef struct packed {
        logic [31:0] res;
        logic        inv;
        logic        inx;
        logic        norm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] operand;
    logic [31:0] result;
    logic        ready;
    logic        done;
    logic        invalid;
    logic        inexact;

    int checks = 0;
    int passed = 0;
    bit pending = 0;
    logic [31:0] last_res = '0;
    logic [1:0]  last_flags = '0;

    fpu_sqrt_unit #(.ITERS(26)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .operand (operand),
        .result  (result),
        .ready   (ready),
        .done    (done),
        .invalid (invalid),
        .inexact (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        else
            passed++;
    endtask

    // Reference: exact integer square root of the scaled significand, then
    // round-to-nearest-even on the top 24 of its 26 bits.
    function automatic exp_t model(input logic [31:0] x);
        exp_t r;
        int e;
        longint unsigned m, rad, lo, hi, mid, q, low;
        bit sticky, up;
        r = '0;
        if (x[30:23] == 8'h00) begin
            r.res = {x[31], 31'd0};
        end else if (x[30:23] == 8'hFF && x[22:0] != 0) begin
            r.res = 32'h7FC00000;
        end else if (x[31]) begin
            r.res = 32'h7FC00000;
            r.inv = 1'b1;
        end else if (x[30:23] == 8'hFF) begin
            r.res = 32'h7F800000;
        end else begin
            e = int'(x[30:23]) - 127;
            m = longint'(x[22:0]) + (64'd1 << 23);
            if (e % 2 != 0) begin
                m = m * 2;
                e = e - 1;
            end
            rad = m << 27;
            lo = 0;
            hi = 64'd1 << 26;
            while (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if (mid * mid <= rad) lo = mid;
                else hi = mid - 1;
            end
            sticky = (rad - lo * lo) != 0;
            q   = lo >> 2;
            low = lo % 4;
            up  = (low == 3) || (low == 2 && (sticky || (q % 2 == 1)));
            q   = q + 64'(up);
            e   = e / 2 + 127;
            if (q >= (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            r.res  = {1'b0, 8'(e), 23'(q)};
            r.inx  = (low != 0) || sticky;
            r.norm = 1'b1;
        end
        return r;
    endfunction

    initial begin : compare
        int   edge_n;
        int   acc;
        int   next_ok;
        int   c;
        int   lat;
        exp_t ex;
        edge_n  = 0;
        acc     = 0;
        next_ok = 0;
        lat     = 0;
        ex      = '0;
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            if (rst) begin
                chk("rst_ready", 64'(ready), 64'd1);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_result", 64'(result), 64'd0);
                chk("rst_flags", 64'({invalid, inexact}), 64'd0);
                pending    = 0;
                next_ok    = edge_n + 1;
                last_res   = '0;
                last_flags = '0;
            end else begin
                if (pending) begin
                    c = edge_n - acc + 1;
                    if (c < lat) begin
                        chk("busy_ready", 64'(ready), 64'd0);
                        chk("busy_done", 64'(done), 64'd0);
                    end else if (c == lat) begin
                        chk("done_ready", 64'(ready), 64'd0);
                        chk("done_pulse", 64'(done), 64'd1);
                        chk("result", 64'(result), 64'(ex.res));
                        chk("invalid", 64'(invalid), 64'(ex.inv));
                        chk("inexact", 64'(inexact), 64'(ex.inx));
                        last_res   = ex.res;
                        last_flags = {ex.inv, ex.inx};
                    end else begin
                        chk("back_ready", 64'(ready), 64'd1);
                        chk("back_done", 64'(done), 64'd0);
                        chk("held_result", 64'(result), 64'(last_res));
                        pending = 0;
                    end
                end else if (!(start && edge_n >= next_ok)) begin
                    chk("idle_ready", 64'(ready), 64'd1);
                    chk("idle_done", 64'(done), 64'd0);
                    chk("idle_result", 64'(result), 64'(last_res));
                    chk("idle_flags", 64'({invalid, inexact}), 64'(last_flags));
                end
                if (!pending && start && edge_n >= next_ok) begin
                    ex      = model(operand);
                    lat     = ex.norm ? LAT_NORMAL : LAT_SPECIAL;
                    acc     = edge_n;
                    next_ok = edge_n + lat + 1;
                    pending = 1;
                    chk("accept_ready", 64'(ready), 64'd0);
                    chk("accept_done", 64'(done), 64'd0);
                end
            end
        end
    end

    task automatic do_op(input logic [31:0] x);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            $display("FAIL ready_timeout: ready=%b expected 1 within 200 cycles", ready);
        end
        start   = 1'b1;
        operand = x;
        @(negedge clk);
        start   = 1'b0;
        operand = $urandom;
    endtask

    localparam logic [31:0] DIRECTED [12] = '{
        32'h40800000, 32'h40000000, 32'h3E800000, 32'hBF800000,
        32'h80000000, 32'h7F800000, 32'h7FA00000, 32'h00000001,
        32'hFF800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000
    };

    initial begin : driver
        exp_t        m;
        logic [31:0] r;
        int          n;
        rst     = 1'b1;
        start   = 1'b0;
        operand = '0;

        m = model(32'h40800000);
        chk("model_4.0", 64'({m.res, m.inx}), 64'({32'h40000000, 1'b0}));
        m = model(32'h40000000);
        chk("model_2.0", 64'({m.res, m.inx}), 64'({32'h3FB504F3, 1'b1}));
        m = model(32'h3E800000);
        chk("model_0.25", 64'({m.res, m.inx}), 64'({32'h3F000000, 1'b0}));
        m = model(32'hBF800000);
        chk("model_neg1", 64'({m.res, m.inv, m.norm}), 64'({32'h7FC00000, 1'b1, 1'b0}));
        m = model(32'h7FA00000);
        chk("model_snan", 64'({m.res, m.inv}), 64'({32'h7FC00000, 1'b0}));

        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (DIRECTED[i]) do_op(DIRECTED[i]);

        // A second start mid-operation must be ignored.
        do_op(32'h40400000);
        repeat (4) @(negedge clk);
        start   = 1'b1;
        operand = 32'h3F800000;
        @(negedge clk);
        start   = 1'b0;

        // Reset partway through, then a fresh operation.
        do_op(32'h41100000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h41100000);

        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            if (i % 2 == 0) begin
                r[31]    = 1'b0;
                r[30:23] = 8'($urandom_range(1, 254));
            end
            do_op(r);
        end

        n = 0;
        while (pending && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (pending) begin
            checks++;
            $display("FAIL final_drain: pending=1 expected 0");
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
